// File: rtl/rom_arbiter_if.sv
// Request/response bundle of rom_arbiter plus the shared ROM address/data pair.
// slave = arbiter side; master = requesters and ROM side.
interface rom_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              busy;

  modport slave (
    input  req0, req1, addr0, addr1, rom_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_addr, busy
  );

  modport master (
    output req0, req1, addr0, addr1, rom_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_addr, busy
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester arbiter sharing one pipelined ROM (read latency RD_LAT cycles).
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module rom_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 2
) (
  input logic          clk,
  input logic          rst_n,
  rom_arbiter_if.slave bus
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr [2];
  logic [1:0]        elig;
  logic              pick1;
  logic              issue;

  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [RD_LAT:0]   tag_valid_q, tag_valid_d;
  logic [RD_LAT:0]   tag_port_q, tag_port_d;
  logic              busy_q, busy_d;

  assign req     = {bus.req1, bus.req0};
  assign addr[0] = bus.addr0;
  assign addr[1] = bus.addr1;

  // A requester whose grant is showing this cycle is not eligible, so a held req is not issued twice.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign elig[gi]     = req[gi] & ~gnt_q[gi];
      assign rvalid_d[gi] = tag_valid_q[RD_LAT] & (tag_port_q[RD_LAT] == (gi != 0));
      assign rdata_d[gi]  = rvalid_d[gi] ? bus.rom_dout : rdata_q[gi];
    end
  endgenerate

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // last_q is the requester granted most recently; the other one wins contention.
  assign pick1 = elig[1] & (~elig[0] | ~last_q);
`else
  assign pick1 = elig[1] & ~elig[0];
`endif

  always_comb begin
    gnt_d      = {pick1, elig[0] & ~pick1};
    issue      = |gnt_d;
    rom_addr_d = rom_addr_q;
    if (gnt_d[0]) begin
      rom_addr_d = addr[0];
    end else if (gnt_d[1]) begin
      rom_addr_d = addr[1];
    end
    tag_valid_d = {tag_valid_q[RD_LAT-1:0], issue};
    tag_port_d  = {tag_port_q[RD_LAT-1:0], gnt_d[1]};
    busy_d      = |tag_valid_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    last_d = issue ? gnt_d[1] : last_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
      rom_addr_q  <= '0;
      tag_valid_q <= '0;
      tag_port_q  <= '0;
      busy_q      <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q[0]  <= rdata_d[0];
      rdata_q[1]  <= rdata_d[1];
      rom_addr_q  <= rom_addr_d;
      tag_valid_q <= tag_valid_d;
      tag_port_q  <= tag_port_d;
      busy_q      <= busy_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.gnt0     = gnt_q[0];
  assign bus.gnt1     = gnt_q[1];
  assign bus.rvalid0  = rvalid_q[0];
  assign bus.rvalid1  = rvalid_q[1];
  assign bus.rdata0   = rdata_q[0];
  assign bus.rdata1   = rdata_q[1];
  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = busy_q;
endmodule
